// File: rtl/result_uart_tx.sv
// Serializes a 32-bit FPU result over a UART 8N1 line, most-significant byte first.
// Define RESULT_UART_TX_ASCII_HEX_EN to send 8 uppercase hex digits plus CR/LF instead.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef RESULT_UART_TX_ASCII_HEX_EN
    localparam int CHR_W = 4;
    localparam int SHIFT = 4;
    localparam logic [CHR_W-1:0] CHR_LAST = 4'd9;
`else
    localparam int CHR_W = 2;
    localparam int SHIFT = 8;
    localparam logic [CHR_W-1:0] CHR_LAST = 2'd3;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [CHR_W-1:0]   chr_q, chr_d;
    logic [31:0]        shreg_q, shreg_d;
    logic               done_q, done_d;
    logic [7:0]         cur_char;

    // The character on the wire always comes from the top of the shift register.
`ifdef RESULT_UART_TX_ASCII_HEX_EN
    logic [3:0] nib;
    always_comb begin
        nib = shreg_q[31:28];
        case (chr_q)
            4'd8:    cur_char = 8'h0D;
            4'd9:    cur_char = 8'h0A;
            default: cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        endcase
    end
`else
    assign cur_char = shreg_q[31:24];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            chr_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            chr_q   <= chr_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        chr_d   = chr_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_START;
                shreg_d = data_in;
                baud_d  = '0;
                bit_d   = '0;
                chr_d   = '0;
            end
        end else if (baud_q != BAUD_LAST) begin
            baud_d = baud_q + 1'b1;
        end else begin
            baud_d = '0;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
                S_DATA: begin
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
                S_STOP: begin
                    if (chr_q == CHR_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Next character starts immediately: no idle gap between frames.
                        state_d = S_START;
                        chr_d   = chr_q + 1'b1;
                        shreg_d = {shreg_q[31-SHIFT:0], SHIFT'(0)};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // txd is decoded from the state flop so an asynchronous reset idles the line at once.
    always_comb begin
        txd  = 1'b1;
        busy = (state_q != S_IDLE);
        done = done_q;
        case (state_q)
            S_START: txd = 1'b0;
            S_DATA:  txd = cur_char[bit_q];
            default: txd = 1'b1;
        endcase
    end

endmodule
